bank_sram_stream_master: RTL and testbench
==========================================

Name: bank_sram_stream_master

Overview:
- Initiator for one request stream of the banked SRAM.
- Accepts a strided block command and issues one request per cycle, honouring the same-cycle grant (req_ready) handshake.
- Read commands: collects responses, which arrive 1 cycle after grant, into a local FIFO and presents them as a valid/ready output stream.
- Write commands: pulls data from a valid/ready input stream.
- One instance sits on each master port of the banked SRAM, for example the attention-score operand fetch and writeback paths.

Parameters:
- ADDR_W, 12, request address width (bank bits are the LSBs and are decoded by the SRAM, not here).
- Data_W, 16, data word width.
- LEN_W, 8, command length counter width.
- FIFO_D, 4, read-response FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accept (IDLE only)
- cmd_we  in  1  1 = write block, 0 = read block
- cmd_base  in  ADDR_W  first address
- cmd_stride  in  ADDR_W  address increment per element
- cmd_len  in  LEN_W  element count (0 allowed)
- wr_valid  in  1  write data valid
- wr_ready  out  1  write data consumed
- wr_data  in  Data_W  write data
- rd_valid  out  1  read data valid
- rd_ready  in  1  read data consumer ready
- rd_data  out  Data_W  read data (FIFO head)
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- req_v  out  1  SRAM request valid
- req_we  out  1  SRAM write enable
- req_addr  out  ADDR_W  SRAM address
- req_wdata  out  Data_W  SRAM write data
- req_ready  in  1  same-cycle grant
- rsp_v  in  1  response valid, 1 cycle after grant
- rsp_rdata  in  Data_W  response data

Behaviour:
- Reset (async): state IDLE; counters, FIFO and the latched command cleared.
  - Outputs: req_v=0, req_we=0, req_addr=0, req_wdata=0, cmd_ready=0 during reset, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0.
  - Reset mid-command aborts it. Responses in flight are discarded and no done pulse is produced.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch we, base, stride, len; clear issue count (icnt) and pending flag.
  - len==0 goes to FIN; otherwise go to RUN.
- RUN, request issue:
  - req_addr = base + icnt*stride mod 2^ADDR_W, kept as a running accumulator; wrap-around is silent.
  - req_we = latched we.
  - Read: req_v = (icnt<len) & (fifo_cnt + pending < FIFO_D).
  - Write: req_v = (icnt<len) & wr_valid. req_wdata = wr_data (combinational). wr_ready = req_v & req_ready.
  - Accept = req_v & req_ready. On accept: icnt++, address += stride, pending <= 1 for reads.
  - Once req_v is high it stays high with stable addr/we/wdata until accepted. The credit check cannot revoke it, because the only in-flight response was already counted.
  - Last accept (icnt becomes len) goes to DRAIN.
- Responses:
  - rsp_v with pending=1 pushes rsp_rdata into the FIFO and clears pending. If a new accept happens in the same cycle, pending stays 1.
  - rsp_v for write commands, or with pending=0, is ignored.
  - The FIFO never overflows, by construction of the credit check.
- DRAIN: wait for pending==0 (at most 1 cycle), then go to FIN.
  - FIN does not wait for the FIFO to empty; rd data may remain in it.
- FIN: done=1 for exactly one cycle, then IDLE. cmd_ready=0 in FIN.
- FIFO output:
  - rd_valid = fifo_cnt!=0; rd_data = head.
  - Pop on rd_valid & rd_ready.
  - Simultaneous push and pop: count unchanged, data order preserved.
  - Push when empty: visible on rd_valid the next cycle (registered FIFO, no bypass).
- Read throughput: 1 element/cycle when req_ready=1 and rd_ready=1 continuously.
- Latency: cmd accept → first req_v 1 cycle; grant → FIFO push 1 cycle; push → rd_valid 1 cycle.
- A new command may be accepted while old read data remains in the FIFO. The credit check naturally throttles it.

Test Plan:
- Read, base=0x010, stride=1, len=4, req_ready=1, rd_ready=1 → req_addr 0x010..0x013 on consecutive cycles; rd_data = memory contents in order; done one cycle after the last response; busy low afterwards.
- Write, base=0x020, stride=8, len=3, wr_data A1,B2,C3, wr_valid gapped every other cycle → writes only when wr_valid; addrs 0x020, 0x028, 0x030; wr_ready pulses == grants; done once.
- Read, len=8, rd_ready=0 → exactly FIFO_D=4 grants then req_v stalls high with addr held. Release rd_ready → remaining 4 issue; order 0..7 preserved.
- req_ready toggled randomly (arbiter contention), read len=6 → req_v never drops or changes addr before accept; 6 responses, no loss or duplication.
- base=0xFFE, stride=1, len=4 → addrs 0xFFE, 0xFFF, 0x000, 0x001; len=0 → done 1 cycle after accept with no req_v.
- rst_n asserted mid-read after 2 grants → all outputs 0 immediately, FIFO empty, no done; next command runs normally.

Source files
------------

// File: rtl/bank_sram_stream_master.sv
// Single-stream initiator for the banked SRAM: walks a strided block command,
// issuing one request per cycle, and buffers read responses in a small FIFO.
module bank_sram_stream_master #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned Data_W = 16,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_stride,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [Data_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [Data_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              req_v,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [Data_W-1:0] req_wdata,
    input  logic              req_ready,
    input  logic              rsp_v,
    input  logic [Data_W-1:0] rsp_rdata
);

    localparam int unsigned PTR_W = $clog2(FIFO_D);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned INF_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t             state, state_nxt;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  stride_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   icnt_q;
    logic               pending_q;

    logic [Data_W-1:0]  mem_q [FIFO_D];
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               cmd_acc;
    logic               accept;
    logic               last_acc;
    logic               push;
    logic               pop;
    logic [INF_W-1:0]   inflight;
    logic               credit_ok;

    // Credit covers both stored entries and the one response still in flight.
    assign inflight  = INF_W'(cnt_q) + INF_W'(pending_q);
    assign credit_ok = inflight < INF_W'(FIFO_D);

    assign cmd_acc  = cmd_valid & cmd_ready;
    assign accept   = req_v & req_ready;
    assign last_acc = accept && (icnt_q + LEN_W'(1) == len_q);
    assign push     = rsp_v & pending_q;
    assign pop      = rd_valid & rd_ready;

    assign wr_ready  = accept & we_q;
    assign req_we    = we_q;
    assign req_addr  = addr_q;
    assign req_wdata = (state == RUN && we_q) ? wr_data : '0;
    assign rd_valid  = cnt_q != '0;
    assign rd_data   = mem_q[rptr_q];

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        req_v     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = rst_n;
                if (cmd_acc) state_nxt = (cmd_len == '0) ? FIN : RUN;
            end
            RUN: begin
                req_v = (icnt_q < len_q) & (we_q ? wr_valid : credit_ok);
                if (last_acc) state_nxt = DRAIN;
            end
            DRAIN: begin
                // The last response lands this cycle or has already landed.
                if (!pending_q || rsp_v) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            stride_q  <= '0;
            len_q     <= '0;
            icnt_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_acc) begin
                we_q     <= cmd_we;
                addr_q   <= cmd_base;
                stride_q <= cmd_stride;
                len_q    <= cmd_len;
                icnt_q   <= '0;
            end else if (accept) begin
                icnt_q <= icnt_q + LEN_W'(1);
                addr_q <= addr_q + stride_q;
            end
            if (cmd_acc)              pending_q <= 1'b0;
            else if (accept && !we_q) pending_q <= 1'b1;
            else if (rsp_v)           pending_q <= 1'b0;
        end
    end

    // Registered read-response FIFO; no bypass from push to rd_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(FIFO_D); i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= rsp_rdata;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop) rptr_q <= rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_sram_stream_master.sv
// Scoreboard bench: SRAM responder returns {4'hA, addr}; expected read data and
// write transactions are queued at issue and checked by a separate monitor.
module tb_bank_sram_stream_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [11:0] cmd_base, cmd_stride;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [15:0] rd_data;
    logic        busy, done;
    logic        req_v, req_we;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_v;
    logic [15:0] rsp_rdata;

    bank_sram_stream_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .req_v(req_v), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_v(rsp_v), .rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int grant_cnt = 0;
    int done_cnt  = 0;
    int wr_hs_cnt = 0;
    int cyc       = 0;
    logic wr_hs   = 1'b0;
    logic rr_rand = 1'b0;
    logic wr_gap  = 1'b0;

    logic [15:0] exp_rd [$];
    logic [27:0] exp_wr [$];
    logic [15:0] wq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // SRAM model: response one cycle after a read grant.
    always begin
        logic        g;
        logic [11:0] a;
        @(negedge clk);
        g = rst_n & req_v & req_ready & ~req_we;
        a = req_addr;
        @(posedge clk);
        #1;
        rsp_v     = g;
        rsp_rdata = g ? {4'hA, a} : 16'h0;
    end

    // Per-cycle driver for arbiter grant and the write data stream.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (wr_hs && wq.size() != 0) void'(wq.pop_front());
        req_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        wr_valid  = (wq.size() != 0) && (!wr_gap || cyc[0]);
        wr_data   = (wq.size() != 0) ? wq[0] : 16'h0;
    end

    // Monitor: request stability, write grants, read stream, done pulses.
    logic        held_v = 1'b0;
    logic [11:0] held_addr;
    logic        held_we;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
            wr_hs  = 1'b0;
        end else begin
            if (held_v) begin
                chk("req_stable", 32'({req_v, req_we, req_addr}), 32'({1'b1, held_we, held_addr}));
            end
            held_v    = req_v & ~req_ready;
            held_addr = req_addr;
            held_we   = req_we;
            if (req_v && req_ready) begin
                grant_cnt++;
                if (req_we) begin
                    if (exp_wr.size() == 0) begin
                        chk("wr_unexpected", 32'(req_addr), 32'hFFFF_FFFF);
                    end else begin
                        logic [27:0] e;
                        e = exp_wr.pop_front();
                        chk("wr_addr", 32'(req_addr), 32'(e[27:16]));
                        chk("wr_data", 32'(req_wdata), 32'(e[15:0]));
                        chk("wr_valid_at_grant", 32'(wr_valid), 32'd1);
                    end
                end
            end
            wr_hs = wr_valid & wr_ready;
            if (wr_hs) wr_hs_cnt++;
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
                end else begin
                    logic [15:0] e;
                    e = exp_rd.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(e));
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic issue(input logic we, input logic [11:0] base, input logic [11:0] stride,
                         input logic [7:0] len);
        int n;
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_we = we; cmd_base = base; cmd_stride = stride; cmd_len = len;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #2; n++;
        end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int max);
        int n;
        n = 0;
        while (!done && n < max) begin
            @(posedge clk); #2; n++;
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
        @(posedge clk); #2;
        chk({nm, "_post_done"}, 32'({done, busy}), 32'd0);
    endtask

    task automatic drain_rd(input string nm);
        int n;
        n = 0;
        while (exp_rd.size() != 0 && n < 100) begin
            @(posedge clk); #2; n++;
        end
        chk({nm, "_drained"}, 32'(exp_rd.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, d0, w0;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_base = '0; cmd_stride = '0; cmd_len = '0;
        rd_ready = 1'b0; req_ready = 1'b1; wr_valid = 1'b0; wr_data = '0;
        rsp_v = 1'b0; rsp_rdata = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ctl", 32'({req_v, req_we, cmd_ready, wr_ready, rd_valid, busy, done}), 32'd0);
        chk("rst_addr", 32'(req_addr), 32'd0);
        chk("rst_data", {req_wdata, rd_data}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Unit-stride read, full throughput.
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_rd.push_back(16'hA010 + 16'(i));
        issue(1'b0, 12'h010, 12'h001, 8'd4);
        wait_done("t1", 40);
        drain_rd("t1");

        // Strided write with a gapped data stream.
        wr_gap = 1'b1;
        wq.push_back(16'h00A1); wq.push_back(16'h00B2); wq.push_back(16'h00C3);
        exp_wr.push_back({12'h020, 16'h00A1});
        exp_wr.push_back({12'h028, 16'h00B2});
        exp_wr.push_back({12'h030, 16'h00C3});
        w0 = wr_hs_cnt; g0 = grant_cnt; d0 = done_cnt;
        issue(1'b1, 12'h020, 12'h008, 8'd3);
        wait_done("t2", 40);
        chk("t2_wr_ready_pulses", 32'(wr_hs_cnt - w0), 32'd3);
        chk("t2_grants", 32'(grant_cnt - g0), 32'd3);
        chk("t2_done_once", 32'(done_cnt - d0), 32'd1);
        wr_gap = 1'b0;

        // Read longer than the FIFO with consumer stalled.
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) exp_rd.push_back(16'hA040 + 16'(i));
        g0 = grant_cnt;
        issue(1'b0, 12'h040, 12'h001, 8'd8);
        repeat (12) begin @(posedge clk); #2; end
        chk("t3_grants_stalled", 32'(grant_cnt - g0), 32'd4);
        chk("t3_addr_hold", 32'(req_addr), 32'h044);
        chk("t3_fifo_head", 32'({rd_valid, rd_data}), 32'({1'b1, 16'hA040}));
        rd_ready = 1'b1;
        wait_done("t3", 60);
        drain_rd("t3");
        chk("t3_grants_total", 32'(grant_cnt - g0), 32'd8);

        // Arbiter contention: random grant.
        for (int i = 0; i < 6; i++) exp_rd.push_back(16'hA100 + 16'(3 * i));
        g0 = grant_cnt;
        rr_rand = 1'b1;
        issue(1'b0, 12'h100, 12'h003, 8'd6);
        wait_done("t4", 200);
        rr_rand = 1'b0;
        drain_rd("t4");
        chk("t4_grants", 32'(grant_cnt - g0), 32'd6);

        // Address wrap-around.
        exp_rd.push_back(16'hAFFE); exp_rd.push_back(16'hAFFF);
        exp_rd.push_back(16'hA000); exp_rd.push_back(16'hA001);
        issue(1'b0, 12'hFFE, 12'h001, 8'd4);
        wait_done("t5", 40);
        drain_rd("t5");

        // Zero-length command.
        g0 = grant_cnt;
        issue(1'b0, 12'h055, 12'h001, 8'd0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_no_req", 32'(grant_cnt - g0), 32'd0);
        @(posedge clk); #2;
        chk("len0_post", 32'({done, busy, req_v}), 32'd0);

        // Reset in the middle of a read.
        rd_ready = 1'b0;
        g0 = grant_cnt; d0 = done_cnt;
        issue(1'b0, 12'h200, 12'h001, 8'd6);
        for (int n = 0; n < 50 && (grant_cnt - g0) < 2; n++) begin
            @(posedge clk); #2;
        end
        chk("t6_two_grants", 32'(grant_cnt - g0), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl", 32'({req_v, req_we, cmd_ready, wr_ready, rd_valid, busy, done}), 32'd0);
        chk("t6_rst_addr", 32'(req_addr), 32'd0);
        chk("t6_rst_data", {req_wdata, rd_data}, 32'd0);
        exp_rd.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        rd_ready = 1'b1;
        repeat (3) begin @(posedge clk); #2; end
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t6_fifo_empty", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 3; i++) exp_rd.push_back(16'hA300 + 16'(i));
        issue(1'b0, 12'h300, 12'h001, 8'd3);
        wait_done("t6_after", 40);
        drain_rd("t6_after");

        chk("end_exp_wr_empty", 32'(exp_wr.size()), 32'd0);
        chk("end_exp_rd_empty", 32'(exp_rd.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
